tx_crc5_engine: RTL and testbench

Bit-serial CRC-5 generator for the HDR-DDR transmit path. It sits directly beside the tx serializer. The serializer hands it each payload byte on `o_crc_parallel_data` / `o_crc_en`. The engine folds that byte into the running I3C CRC-5, polynomial x^5+x^2+1, seed 5'h1F, MSB first. After the last byte of a frame it returns the final value on `i_crc_crc_value` / `i_crc_crc_valid` for the serializer's CRC_value mode.

---
 rtl/tx_crc5_pkg.sv | 30 +++
 rtl/tx_crc5_engine.sv | 154 +++++++++++++++
 tb/tb_tx_crc5_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_crc5_pkg.sv
// Shared CRC-5 constants, state encoding and reference step functions for the
// HDR-DDR transmit CRC engine (x^5+x^2+1, MSB first).
package tx_crc5_pkg;

    localparam logic [4:0] CRC5_SEED = 5'h1F;
    localparam logic [4:0] CRC5_POLY = 5'h05;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } crc_state_e;

    // Galois form: shift left, xor the polynomial taps when the feedback bit is set
    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic d);
        logic fb;
        fb = crc[4] ^ d;
        return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
    endfunction

    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = crc5_step(c, data[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_crc5_engine.sv
// CRC-5 generator beside the tx serializer. Bit-serial by default; define
// TX_CRC5_PARALLEL_EN to fold a whole byte per cycle.
module tx_crc5_engine
    import tx_crc5_pkg::*;
(
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_ddrccc_crc_init,
    input  logic       i_txcrc_en,
    input  logic [7:0] i_txcrc_parallel_data,
    input  logic       i_ddrccc_crc_last,
    output logic       o_crc_ready,
    output logic [4:0] o_crc_crc_value,
    output logic       o_crc_crc_valid,
    output logic       o_crc_overrun
);

    crc_state_e state_q, state_d;
    logic [4:0] crc_q, crc_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       ready_q, ready_d;

`ifdef TX_CRC5_PARALLEL_EN

    logic [4:0] base_s;

    // Next-state: whole byte folded in one cycle; init reseeds before the fold
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        valid_d   = valid_q;
        overrun_d = init_clear_overrun(i_ddrccc_crc_init, overrun_q);
        ready_d   = 1'b1;
        base_s    = i_ddrccc_crc_init ? CRC5_SEED : crc_q;
        if (i_txcrc_en) begin
            crc_d   = crc5_byte(base_s, i_txcrc_parallel_data);
            valid_d = i_ddrccc_crc_last;
            state_d = i_ddrccc_crc_last ? DONE : IDLE;
        end else if (i_ddrccc_crc_init) begin
            crc_d   = CRC5_SEED;
            valid_d = 1'b0;
            state_d = IDLE;
        end else begin
            crc_d   = crc_q;
        end
    end

    function automatic logic init_clear_overrun(input logic init, input logic ovr);
        return init ? 1'b0 : ovr;
    endfunction

`else

    logic [7:0] shreg_q, shreg_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_q, last_d;

    // Next-state: init overrides everything but may still accept the same-cycle byte
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        if (i_ddrccc_crc_init) begin
            crc_d     = CRC5_SEED;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
            cnt_d     = 3'd0;
            state_d   = IDLE;
            if (i_txcrc_en) begin
                shreg_d = i_txcrc_parallel_data;
                last_d  = i_ddrccc_crc_last;
                state_d = SHIFT;
            end else begin
                last_d  = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_txcrc_en) begin
                        shreg_d = i_txcrc_parallel_data;
                        last_d  = i_ddrccc_crc_last;
                        cnt_d   = 3'd0;
                        valid_d = 1'b0;
                        state_d = SHIFT;
                    end else begin
                        state_d = state_q;
                    end
                end
                SHIFT: begin
                    crc_d = crc5_step(crc_q, shreg_q[3'd7 - cnt_q]);
                    cnt_d = cnt_q + 3'd1;
                    if (i_txcrc_en) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                    if (cnt_q == 3'd7) begin
                        state_d = last_q ? DONE : IDLE;
                        valid_d = last_q;
                    end else begin
                        state_d = SHIFT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        ready_d = (state_d != SHIFT);
    end

    // Byte datapath registers
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            shreg_q <= 8'h00;
            cnt_q   <= 3'd0;
            last_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

`endif

    // State and output registers
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q   <= IDLE;
            crc_q     <= CRC5_SEED;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ready_q   <= ready_d;
        end
    end

    assign o_crc_ready     = ready_q;
    assign o_crc_crc_value = crc_q;
    assign o_crc_crc_valid = valid_q;
    assign o_crc_overrun   = overrun_q;

endmodule

// File: tb/tb_tx_crc5_engine.sv
// Scoreboard bench for tx_crc5_engine: stimulus pushes expected final CRCs,
// a monitor pops and compares on each rising o_crc_crc_valid.
module tb_tx_crc5_engine;

    logic       clk;
    logic       rst_n;
    logic       init;
    logic       en;
    logic [7:0] data;
    logic       last;
    logic       ready;
    logic [4:0] value;
    logic       valid;
    logic       overrun;

    int checks = 0;
    int passes = 0;
    logic [4:0] exp_q[$];
    logic       valid_prev = 1'b0;

    tx_crc5_engine dut (
        .i_sys_clk             (clk),
        .i_sys_rst             (rst_n),
        .i_ddrccc_crc_init     (init),
        .i_txcrc_en            (en),
        .i_txcrc_parallel_data (data),
        .i_ddrccc_crc_last     (last),
        .o_crc_ready           (ready),
        .o_crc_crc_value       (value),
        .o_crc_crc_valid       (valid),
        .o_crc_overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model written directly from the spec's bit-level step
    function automatic logic [4:0] ref_byte(input logic [4:0] c_in, input logic [7:0] b);
        logic [4:0] c;
        logic fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[4] ^ b[i];
            c  = {c[3], c[2], c[1] ^ fb, c[0], fb};
        end
        return c;
    endfunction

    // Monitor: rising valid marks a finished frame
    always @(negedge clk) begin
        if (rst_n && valid && !valid_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(value), 32'h0);
            end else begin
                chk("final_crc", 32'(value), 32'(exp_q.pop_front()));
            end
        end
        valid_prev <= valid;
    end

    task automatic strobe(input logic [7:0] b, input logic l, input logic i);
        @(negedge clk);
        en = 1'b1; data = b; last = l; init = i;
        @(posedge clk);
        #1;
        en = 1'b0; last = 1'b0; init = 1'b0;
    endtask

    task automatic pulse_init();
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
    endtask

    // Counts negedges with ready low, checks valid stays low meanwhile
    task automatic wait_ready(output int lows);
        int bad;
        lows = 0;
        bad = 0;
        @(negedge clk);
        while (!ready && lows < 20) begin
            if (valid) bad++;
            lows++;
            @(negedge clk);
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'h1);
        chk("valid_low_in_shift", 32'(bad), 32'h0);
    endtask

    int lows;
    int exp_lows;
    logic [7:0] rb;
    logic [4:0] rexp;

    initial begin
`ifdef TX_CRC5_PARALLEL_EN
        exp_lows = 0;
`else
        exp_lows = 8;
`endif
        rst_n = 1'b0; init = 1'b0; en = 1'b0; data = 8'h00; last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_value", 32'(value), 32'h1F);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;

        // 1: single zero byte
        pulse_init();
        exp_q.push_back(5'h0F);
        strobe(8'h00, 1'b1, 1'b0);
        wait_ready(lows);
        chk("t1_ready_low_cycles", 32'(lows), 32'(exp_lows));
        chk("t1_valid", 32'(valid), 32'h1);

        // 2: two zero bytes
        pulse_init();
        strobe(8'h00, 1'b0, 1'b0);
        wait_ready(lows);
        chk("t2_valid_between", 32'(valid), 32'h0);
        chk("t2_mid_value", 32'(value), 32'h0F);
        exp_q.push_back(5'h01);
        strobe(8'h00, 1'b1, 1'b0);
        wait_ready(lows);

        // 3: overrun during SHIFT
        pulse_init();
        exp_q.push_back(ref_byte(5'h1F, 8'hAB));
        strobe(8'hAB, 1'b1, 1'b0);
`ifndef TX_CRC5_PARALLEL_EN
        repeat (2) @(negedge clk);
        en = 1'b1; data = 8'hFF; last = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0; last = 1'b0;
        @(negedge clk);
        chk("t3_overrun_set", 32'(overrun), 32'h1);
`endif
        wait_ready(lows);
        pulse_init();
        @(negedge clk);
        chk("t3_overrun_cleared", 32'(overrun), 32'h0);

        // 4: init mid-byte
        strobe(8'h5A, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pulse_init();
        @(negedge clk);
        chk("t4_value", 32'(value), 32'h1F);
        chk("t4_ready", 32'(ready), 32'h1);
        chk("t4_valid", 32'(valid), 32'h0);

        // 5: init and strobe together over a stale CRC
        strobe(8'h33, 1'b0, 1'b0);
        wait_ready(lows);
        chk("t5_stale", 32'(value), 32'(ref_byte(5'h1F, 8'h33)));
        exp_q.push_back(5'h0F);
        strobe(8'h00, 1'b1, 1'b1);
        wait_ready(lows);

        // 6: async reset mid-byte, then a random frame
        pulse_init();
        strobe(8'h77, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_value", 32'(value), 32'h1F);
        chk("t6_rst_valid", 32'(valid), 32'h0);
        chk("t6_rst_ready", 32'(ready), 32'h1);
        chk("t6_rst_overrun", 32'(overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rexp = 5'h1F;
        pulse_init();
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom_range(0, 255));
            rexp = ref_byte(rexp, rb);
            if (k == 3) exp_q.push_back(rexp);
            strobe(rb, (k == 3), 1'b0);
            wait_ready(lows);
        end
        chk("t6_rand_value", 32'(value), 32'(rexp));

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
